scr1_tcm_arb: RTL and testbench

Single-port TCM arbiter. It shares one single-port synchronous SRAM between the core instruction port (imem) and data port (dmem), both using the SCR1 req/ack/resp protocol. It performs byte-lane steering for sub-word stores and loads, routes each registered response back to the granted requester, and uses a starvation counter so imem cannot be locked out by back-to-back data traffic. It sits between the core memory ports and a single-port memory macro, in configurations where a dual-port TCM is not available.

---
 rtl/scr1_tcm_arb_if.sv | 32 +++
 rtl/scr1_tcm_arb.sv | 113 +++++++++++
 tb/tb_scr1_tcm_arb.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_tcm_arb_if.sv
// Core-side req/ack/resp bundle for the TCM arbiter: instruction (imem) and data (dmem) ports.
// The core drives the master modport; the arbiter takes the slave modport.
interface scr1_tcm_arb_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_req_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_resp;

    logic        dmem_req;
    logic        dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;

    modport master (
        output imem_req, imem_addr,
        input  imem_req_ack, imem_rdata, imem_resp,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_req_ack, imem_rdata, imem_resp,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/scr1_tcm_arb.sv
// Single-port TCM arbiter between SCR1 imem and dmem with byte-lane steering and imem starvation guard.
// Define SCR1_TCM_ARB_ERR_EN to enable out-of-range / misalignment checking (resp=10, no SRAM access).
module scr1_tcm_arb #(
    parameter int unsigned SCR1_TCM_SIZE = 32'h00010000,
    parameter int unsigned STARVE_MAX    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    scr1_tcm_arb_if.slave                      core,
    output logic                               mem_en,
    output logic                               mem_we,
    output logic [3:0]                         mem_be,
    output logic [$clog2(SCR1_TCM_SIZE)-3:0]   mem_addr,
    output logic [31:0]                        mem_wdata,
    input  logic [31:0]                        mem_rdata
);

    localparam int unsigned AW         = $clog2(SCR1_TCM_SIZE) - 2;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  starve_q, starve_d;
    logic        rvld_q, rown_q, rerr_q;
    logic [1:0]  roff_q;

    logic        starved, imem_gnt, dmem_gnt, imem_err, dmem_err, acc_err;
    logic [31:0] acc_addr;
    logic [1:0]  resp_code;

    // Grant: dmem has priority unless imem has already waited STARVE_MAX dmem grants.
    assign starved  = (starve_q == STARVE_LIM);
    assign dmem_gnt = ~rst & core.dmem_req & ~(core.imem_req & starved);
    assign imem_gnt = ~rst & core.imem_req & ~dmem_gnt;

    assign core.dmem_req_ack = dmem_gnt;
    assign core.imem_req_ack = imem_gnt;

`ifdef SCR1_TCM_ARB_ERR_EN
    localparam logic [32:0] SIZE33 = 33'(SCR1_TCM_SIZE);
    assign imem_err = ({1'b0, core.imem_addr} >= SIZE33);
    assign dmem_err = ({1'b0, core.dmem_addr} >= SIZE33)
                    | ((core.dmem_width == 2'b01) & core.dmem_addr[0])
                    | (core.dmem_width[1] & (|core.dmem_addr[1:0]));
`else
    assign imem_err = 1'b0;
    assign dmem_err = 1'b0;
`endif

    assign acc_err  = dmem_gnt ? dmem_err : imem_err;
    assign acc_addr = dmem_gnt ? core.dmem_addr : core.imem_addr;

    assign mem_en   = (dmem_gnt | imem_gnt) & ~acc_err;
    assign mem_we   = dmem_gnt & core.dmem_cmd & ~dmem_err;
    assign mem_addr = acc_addr[AW+1:2];

    // Sub-word stores replicate the right-aligned data across every lane and let mem_be pick.
    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = core.dmem_wdata;
        if (dmem_gnt & core.dmem_cmd) begin
            case (core.dmem_width)
                2'b00: begin
                    mem_be    = 4'b0001 << core.dmem_addr[1:0];
                    mem_wdata = {4{core.dmem_wdata[7:0]}};
                end
                2'b01: begin
                    mem_be    = 4'b0011 << {core.dmem_addr[1], 1'b0};
                    mem_wdata = {2{core.dmem_wdata[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = core.dmem_wdata;
                end
            endcase
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!core.imem_req || imem_gnt) begin
            starve_d = 4'd0;
        end else if (dmem_gnt && !starved) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= 4'd0;
            rvld_q   <= 1'b0;
            rown_q   <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            starve_q <= starve_d;
            rvld_q   <= imem_gnt | dmem_gnt;
            rown_q   <= dmem_gnt;
            rerr_q   <= acc_err;
        end
    end

    // Load offset is datapath only; it is consulted solely while a dmem response is valid.
    always_ff @(posedge clk) begin
        if (dmem_gnt) begin
            roff_q <= core.dmem_addr[1:0];
        end
    end

    assign resp_code       = rerr_q ? 2'b10 : 2'b01;
    assign core.imem_resp  = (rvld_q & ~rown_q) ? resp_code : 2'b00;
    assign core.dmem_resp  = (rvld_q &  rown_q) ? resp_code : 2'b00;
    assign core.imem_rdata = rerr_q ? 32'd0 : mem_rdata;
    assign core.dmem_rdata = rerr_q ? 32'd0 : (mem_rdata >> {roff_q, 3'b000});

endmodule

// File: tb/tb_scr1_tcm_arb.sv
// Directed table-driven bench for scr1_tcm_arb with a byte-enabled synchronous SRAM model.
module tb_scr1_tcm_arb;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   sram [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    scr1_tcm_arb_if bus();

    scr1_tcm_arb #(.SCR1_TCM_SIZE(32'h00010000), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .core(bus),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= sram[mem_addr];
        end
    end

    typedef struct {
        logic        ireq;  logic [31:0] iaddr;
        logic        dreq;  logic dcmd; logic [1:0] dw; logic [31:0] daddr; logic [31:0] dwd;
        logic        iack;  logic dack; logic en; logic we;
        logic [3:0]  be;    logic [31:0] wd; logic [AW-1:0] ma;
        logic [1:0]  iresp; logic [1:0] dresp;
        logic        chk;   logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                         input logic dcmd, input logic [1:0] dw, input logic [31:0] daddr,
                         input logic [31:0] dwd);
        bus.imem_req   = ireq;  bus.imem_addr  = iaddr;
        bus.dmem_req   = dreq;  bus.dmem_cmd   = dcmd;
        bus.dmem_width = dw;    bus.dmem_addr  = daddr;  bus.dmem_wdata = dwd;
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{ireq:0, iaddr:0, dreq:0, dcmd:0, dw:0, daddr:0, dwd:0, iack:0, dack:0, en:0, we:0,
              be:4'hF, wd:0, ma:0, iresp:2'b00, dresp:2'b00, chk:0, rd:0};
        return v;
    endfunction

    function automatic vec_t fe(input logic [31:0] a, input logic [AW-1:0] ma, input logic [31:0] rd);
        vec_t v = idle();
        v.ireq = 1; v.iaddr = a; v.iack = 1; v.en = 1; v.ma = ma;
        v.iresp = 2'b01; v.chk = 1; v.rd = rd;
        return v;
    endfunction

    function automatic vec_t ld(input logic [1:0] w, input logic [31:0] a, input logic [AW-1:0] ma,
                                input logic [31:0] rd);
        vec_t v = idle();
        v.dreq = 1; v.dw = w; v.daddr = a; v.dack = 1; v.en = 1; v.ma = ma;
        v.dresp = 2'b01; v.chk = 1; v.rd = rd;
        return v;
    endfunction

    function automatic vec_t st(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic [31:0] wd, input logic [AW-1:0] ma);
        vec_t v = idle();
        v.dreq = 1; v.dcmd = 1; v.dw = w; v.daddr = a; v.dwd = d;
        v.dack = 1; v.en = 1; v.we = 1; v.be = be; v.wd = wd; v.ma = ma; v.dresp = 2'b01;
        return v;
    endfunction

    function automatic vec_t err(input vec_t vi);
        vec_t v = vi;
        v.en = 0; v.we = 0; v.chk = 1; v.rd = 32'd0;
        if (v.iack) v.iresp = 2'b10; else v.dresp = 2'b10;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        logic [7:0] sq_ireq, sq_igrant;

        // Preload via word stores, then sub-word steering and shifted loads.
        vecs.push_back(st(2'b10, 32'h100, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 14'h40));
        vecs.push_back(st(2'b10, 32'h000, 32'h11223344, 4'hF, 32'h11223344, 14'h00));
        vecs.push_back(st(2'b10, 32'h010, 32'h55667788, 4'hF, 32'h55667788, 14'h04));
        vecs.push_back(st(2'b10, 32'h200, 32'h00000000, 4'hF, 32'h00000000, 14'h80));
        vecs.push_back(fe(32'h100, 14'h40, 32'hDEADBEEF));
        vecs.push_back(st(2'b00, 32'h203, 32'h123456A5, 4'b1000, 32'hA5A5A5A5, 14'h80));
        vecs.push_back(ld(2'b00, 32'h203, 14'h80, 32'h000000A5));
        vecs.push_back(st(2'b01, 32'h202, 32'hFFFFBEEF, 4'b1100, 32'hBEEFBEEF, 14'h80));
        vecs.push_back(st(2'b01, 32'h200, 32'h00001234, 4'b0011, 32'h12341234, 14'h80));
        vecs.push_back(ld(2'b10, 32'h200, 14'h80, 32'hBEEF1234));
        vecs.push_back(ld(2'b01, 32'h202, 14'h80, 32'h0000BEEF));
        vecs.push_back(ld(2'b00, 32'h201, 14'h80, 32'h00BEEF12));
        vecs.push_back(st(2'b00, 32'h201, 32'h00000077, 4'b0010, 32'h77777777, 14'h80));
        vecs.push_back(ld(2'b00, 32'h200, 14'h80, 32'hBEEF7734));
        vecs.push_back(st(2'b10, 32'h204, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 14'h81));
        v = ld(2'b10, 32'h204, 14'h81, 32'hCAFEF00D); v.ireq = 1; v.iaddr = 32'h100;
        vecs.push_back(v);
        vecs.push_back(idle());
`ifdef SCR1_TCM_ARB_ERR_EN
        vecs.push_back(err(ld(2'b10, 32'h00010000, 14'h00, 32'h0)));
        vecs.push_back(err(ld(2'b01, 32'h00000011, 14'h04, 32'h0)));
        vecs.push_back(err(fe(32'h00010100, 14'h40, 32'h0)));
`else
        vecs.push_back(ld(2'b10, 32'h00010000, 14'h00, 32'h11223344));
        vecs.push_back(ld(2'b01, 32'h00000011, 14'h04, 32'h00556677));
        vecs.push_back(fe(32'h00010100, 14'h40, 32'hDEADBEEF));
`endif

        // Reset with both requesters asserted: nothing may be acked or enabled.
        rst = 1'b1;
        drive(1, 32'h100, 1, 1, 2'b10, 32'h200, 32'h0);
        #12;
        check("rst_iack", 32'(bus.imem_req_ack), 32'd0);
        check("rst_dack", 32'(bus.dmem_req_ack), 32'd0);
        check("rst_en",   32'(mem_en), 32'd0);
        check("rst_we",   32'(mem_we), 32'd0);
        check("rst_iresp", 32'(bus.imem_resp), 32'd0);
        check("rst_dresp", 32'(bus.dmem_resp), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 2'b00, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.ireq, v.iaddr, v.dreq, v.dcmd, v.dw, v.daddr, v.dwd);
            #1;
            check($sformatf("v%0d_iack", i), 32'(bus.imem_req_ack), 32'(v.iack));
            check($sformatf("v%0d_dack", i), 32'(bus.dmem_req_ack), 32'(v.dack));
            check($sformatf("v%0d_en", i), 32'(mem_en), 32'(v.en));
            check($sformatf("v%0d_we", i), 32'(mem_we), 32'(v.we));
            if (v.en) begin
                check($sformatf("v%0d_be", i), 32'(mem_be), 32'(v.be));
                check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(v.ma));
            end
            if (v.we) check($sformatf("v%0d_wdata", i), mem_wdata, v.wd);
            @(posedge clk); #1;
            check($sformatf("v%0d_iresp", i), 32'(bus.imem_resp), 32'(v.iresp));
            check($sformatf("v%0d_dresp", i), 32'(bus.dmem_resp), 32'(v.dresp));
            if (v.chk) begin
                if (v.iack) check($sformatf("v%0d_irdata", i), bus.imem_rdata, v.rd);
                else        check($sformatf("v%0d_drdata", i), bus.dmem_rdata, v.rd);
            end
            @(negedge clk);
        end

        // Continuous contention: D,D,D,D,I repeating.
        for (int c = 0; c < 15; c++) begin
            drive(1, 32'h100, 1, 0, 2'b10, 32'h204, 32'h0);
            #1;
            check($sformatf("starve%0d_iack", c), 32'(bus.imem_req_ack), 32'((c % 5) == 4));
            check($sformatf("starve%0d_dack", c), 32'(bus.dmem_req_ack), 32'((c % 5) != 4));
            @(posedge clk); #1;
            check($sformatf("starve%0d_iresp", c), 32'(bus.imem_resp), ((c % 5) == 4) ? 32'd1 : 32'd0);
            check($sformatf("starve%0d_dresp", c), 32'(bus.dmem_resp), ((c % 5) != 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // A cycle with imem_req low restarts the count.
        drive(0, 0, 0, 0, 2'b00, 0, 0);
        @(negedge clk);
        sq_ireq   = 8'b1111_1011;
        sq_igrant = 8'b1000_0000;
        for (int c = 0; c < 8; c++) begin
            drive(sq_ireq[c], 32'h100, 1, 0, 2'b10, 32'h204, 32'h0);
            #1;
            check($sformatf("clr%0d_iack", c), 32'(bus.imem_req_ack), 32'(sq_igrant[c]));
            check($sformatf("clr%0d_dack", c), 32'(bus.dmem_req_ack), 32'(!sq_igrant[c]));
            @(negedge clk);
        end

        // Reset right after an ack drops the pending response.
        drive(0, 0, 0, 0, 2'b00, 0, 0);
        @(negedge clk);
        drive(1, 32'h100, 0, 0, 2'b00, 0, 0);
        #1;
        check("rstmid_iack", 32'(bus.imem_req_ack), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rstmid_iresp", 32'(bus.imem_resp), 32'd0);
        check("rstmid_dresp", 32'(bus.dmem_resp), 32'd0);
        check("rstmid_iack_held", 32'(bus.imem_req_ack), 32'd0);
        check("rstmid_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 2'b00, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst%0d_iresp", c), 32'(bus.imem_resp), 32'd0);
            check($sformatf("post_rst%0d_dresp", c), 32'(bus.dmem_resp), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
